// File: rtl/flit_input_route_buffer_pkg.sv
// Shared types for the input route buffer: flit type encoding, FSM states
// and the type-field position helper.
package flit_input_route_buffer_pkg;

   typedef enum logic [1:0] {
      FT_INVALID = 2'b00,
      FT_HEAD    = 2'b01,
      FT_BODY    = 2'b10,
      FT_TAIL    = 2'b11
   } flit_type_t;

   typedef enum logic {
      ST_IDLE,
      ST_IN_PACKET
   } rb_state_t;

   localparam int unsigned FT_BITS = 2;

   // Type field occupies the top bits of every flit.
   function automatic int unsigned type_lsb(input int unsigned data_width,
                                            input int unsigned type_width);
      return data_width - type_width;
   endfunction

endpackage

// File: rtl/flit_input_route_buffer_if.sv
// Link bundle between an upstream/downstream agent (master) and the
// input route buffer (slave).
interface flit_input_route_buffer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TYPE_WIDTH = 2,
   parameter int unsigned PORT_BITS  = 3
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_in_valid;
   logic                  data_in_ready;
   logic [DATA_WIDTH-1:0] data_out;
   logic [TYPE_WIDTH-1:0] flitType;
   logic                  updateHeadFlit;
   logic [DATA_WIDTH-1:0] newHeadFlit;
   logic [PORT_BITS-1:0]  route_port;
   logic                  data_out_valid;
   logic                  data_out_ready;
   logic                  proto_error;

   modport master (
      output data_in, data_in_valid, data_out_ready,
      input  data_in_ready, data_out, flitType, updateHeadFlit, newHeadFlit,
             route_port, data_out_valid, proto_error
   );

   modport slave (
      input  data_in, data_in_valid, data_out_ready,
      output data_in_ready, data_out, flitType, updateHeadFlit, newHeadFlit,
             route_port, data_out_valid, proto_error
   );
endinterface

// File: rtl/flit_input_route_buffer_fifo.sv
// Synchronous FIFO with registered storage; a write in cycle N appears on
// rd_data in cycle N+1. Pointers carry one extra wrap bit.
module flit_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_en,
   output logic                  empty
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  do_wr, do_rd;

   always_comb begin
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   end

   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end
endmodule

// File: rtl/flit_input_route_buffer.sv
// Input-port flit buffer: queues flits, extracts the next-hop port from each
// head flit, holds it until the tail and drops flits that break framing.
module flit_input_route_buffer
   import flit_input_route_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned TYPE_WIDTH  = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ROUTE_WIDTH = 12,
   parameter int unsigned PORT_BITS   = 3,
   parameter bit          UPDATE_EN   = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   flit_input_route_buffer_if.slave  link
);
   localparam int unsigned TYPE_LSB = type_lsb(DATA_WIDTH, TYPE_WIDTH);

   rb_state_t             state_q, state_d;
   logic [PORT_BITS-1:0]  route_q, route_d;

   logic [DATA_WIDTH-1:0] head;
   logic [TYPE_WIDTH-1:0] type_field;
   flit_type_t            head_type;
   logic [PORT_BITS-1:0]  head_port;
   logic [DATA_WIDTH-1:0] new_head;
   logic                  fifo_full, fifo_empty, fifo_rd;
   logic                  is_head, drop, out_valid, read_hs, proto_err;

   flit_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (link.data_in),
      .wr_en   (link.data_in_valid),
      .full    (fifo_full),
      .rd_data (head),
      .rd_en   (fifo_rd),
      .empty   (fifo_empty)
   );

   always_comb begin
      type_field = head[TYPE_LSB +: TYPE_WIDTH];
      head_type  = flit_type_t'(type_field[FT_BITS-1:0]);
      head_port  = head[PORT_BITS-1:0];

      new_head                    = head;
      new_head[ROUTE_WIDTH-1:0]   = {{PORT_BITS{1'b0}}, head[ROUTE_WIDTH-1:PORT_BITS]};

      is_head   = !fifo_empty && (head_type == FT_HEAD);
      // Orphan body/tail flits outside a packet and INVALID flits anywhere
      // are popped without a downstream handshake.
      drop      = !fifo_empty && ((head_type == FT_INVALID) ||
                                  ((state_q == ST_IDLE) && (head_type != FT_HEAD)));
      out_valid = !fifo_empty && !drop;
      read_hs   = out_valid && link.data_out_ready;
      fifo_rd   = read_hs || drop;

      state_d   = state_q;
      route_d   = route_q;
      proto_err = drop;

      if (read_hs) begin
         case (head_type)
            FT_HEAD: begin
               route_d = head_port;
               state_d = ST_IN_PACKET;
               // A head inside an open packet restarts it; flagged once, on its read.
               if (state_q == ST_IN_PACKET) proto_err = 1'b1;
            end
            FT_TAIL: state_d = ST_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         route_q <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
      end
   end

   // A waiting head always advertises its own port so the allocator sees
   // the new route before the handshake that latches it.
   assign link.route_port     = is_head ? head_port : route_q;
   assign link.data_in_ready  = !fifo_full;
   assign link.data_out       = head;
   assign link.flitType       = type_field;
   assign link.newHeadFlit    = new_head;
   assign link.updateHeadFlit = UPDATE_EN && is_head;
   assign link.data_out_valid = out_valid;
   assign link.proto_error    = proto_err;
endmodule

// File: tb/tb_flit_input_route_buffer.sv
// Scoreboard bench for flit_input_route_buffer: a packet-level reference
// model predicts every emitted or dropped flit; a monitor checks the DUT.
module tb_flit_input_route_buffer;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   flit_input_route_buffer_if #(.DATA_WIDTH(DW), .TYPE_WIDTH(2), .PORT_BITS(3)) link ();

   flit_input_route_buffer #(
      .DATA_WIDTH  (DW),
      .TYPE_WIDTH  (2),
      .FIFO_DEPTH  (4),
      .ROUTE_WIDTH (12),
      .PORT_BITS   (3),
      .UPDATE_EN   (1'b1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link.slave)
   );

   typedef struct {
      bit          drop;
      logic [31:0] flit;
      logic [2:0]  port;
      bit          err;
   } exp_t;

   exp_t        sb[$];
   int unsigned emit_cyc[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;
   bit          in_pkt   = 0;
   logic [2:0]  cur_port = '0;
   bit          done     = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   // Packet framing rules applied to the accepted flit stream, in order.
   task automatic model_push(input logic [31:0] f);
      exp_t e;
      logic [1:0] t;
      t      = f[31:30];
      e.flit = f;
      e.drop = 0;
      e.err  = 0;
      if (t == 2'b01) begin
         e.err    = in_pkt;
         cur_port = f[2:0];
         in_pkt   = 1;
      end else if (t == 2'b00 || !in_pkt) begin
         e.drop = 1;
         e.err  = 1;
      end else if (t == 2'b11) begin
         in_pkt = 0;
      end
      e.port = cur_port;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] shifted(input logic [31:0] f);
      return ((f >> 12) << 12) | ((f & 32'hFFF) >> 3);
   endfunction

   task automatic send(input logic [31:0] f);
      int unsigned w;
      w = 0;
      link.data_in       = f;
      link.data_in_valid = 1'b1;
      @(negedge clk);
      while (!link.data_in_ready && w < 100) begin
         w++;
         @(negedge clk);
      end
      if (!link.data_in_ready) begin
         n_checks++;
         $display("FAIL send_timeout flit=%h data_in_ready=0 expected=1", f);
      end else begin
         model_push(f);
      end
      @(posedge clk);
      #1;
      link.data_in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         w++;
         @(negedge clk);
      end
      check("drain_remaining", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per handshake or drop pulse.
   initial begin : monitor
      exp_t e;
      bit   hs;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            hs = link.data_out_valid && link.data_out_ready;
            if (hs) emit_cyc.push_back(cyc);
            if (hs || link.proto_error) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_output data_out=%h expected none", link.data_out);
               end else begin
                  e = sb.pop_front();
                  check("is_drop", {63'd0, !hs}, {63'd0, e.drop});
                  check("data_out", link.data_out, e.flit);
                  if (hs) begin
                     check("route_port", link.route_port, e.port);
                     check("flitType", link.flitType, e.flit[31:30]);
                     check("newHeadFlit", link.newHeadFlit, shifted(e.flit));
                     check("updateHeadFlit", link.updateHeadFlit, e.flit[31:30] == 2'b01);
                     check("proto_error", link.proto_error, e.err);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] s_data;
      logic [2:0]  s_port;
      int unsigned err_cnt, v_seen;
      logic [31:0] f;
      int unsigned r;
      logic [1:0]  t;

      link.data_in        = '0;
      link.data_in_valid  = 1'b0;
      link.data_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", link.data_in_ready, 1);
      check("rst_out_valid", link.data_out_valid, 0);
      check("rst_outputs", {link.data_out, link.newHeadFlit, link.route_port,
                            link.flitType, link.updateHeadFlit, link.proto_error}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Head 0xA5 route: port 5, shifted route 0x014.
      send(32'h4000_00A5);
      @(negedge clk);
      check("a5_route", link.route_port, 5);
      check("a5_new_head", link.newHeadFlit, 32'h4000_0014);
      check("a5_update", link.updateHeadFlit, 1);
      check("a5_valid", link.data_out_valid, 1);
      @(posedge clk);
      #1;
      send(32'h8000_0123);
      send(32'hC000_0000);
      link.data_out_ready = 1'b1;
      wait_drain();

      // Fill under backpressure, refuse a fifth write, then free one slot.
      link.data_out_ready = 1'b0;
      send(32'h4000_0002);
      send(32'h8000_0AAA);
      send(32'h8000_0BBB);
      send(32'hC000_0CCC);
      @(negedge clk);
      check("full_ready", link.data_in_ready, 0);
      s_data = link.data_out;
      s_port = link.route_port;
      @(posedge clk);
      #1;
      link.data_in       = 32'h8000_0DDD;
      link.data_in_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("fifth_refused", link.data_in_ready, 0);
      check("stall_stable", {link.data_out, link.route_port, link.data_out_valid},
            {s_data, s_port, 1'b1});
      @(posedge clk);
      #1;
      link.data_in_valid  = 1'b0;
      link.data_out_ready = 1'b1;
      @(negedge clk);
      check("ready_during_read", link.data_in_ready, 0);
      @(posedge clk);
      #1;
      link.data_out_ready = 1'b0;
      @(negedge clk);
      check("ready_after_read", link.data_in_ready, 1);
      @(posedge clk);
      #1;
      link.data_out_ready = 1'b1;
      wait_drain();

      // Body in IDLE: dropped with a single-cycle error pulse.
      send(32'h8000_0001);
      err_cnt = 0;
      v_seen  = 0;
      repeat (4) begin
         @(negedge clk);
         if (link.proto_error) err_cnt++;
         if (link.data_out_valid) v_seen++;
      end
      check("orphan_err_cycles", err_cnt, 1);
      check("orphan_valid_cycles", v_seen, 0);
      @(posedge clk);
      #1;
      wait_drain();

      // Head followed by a second head before any tail.
      send(32'h4000_0011);
      send(32'h4000_0003);
      send(32'hC000_0000);
      wait_drain();

      // Back-to-back single-flit-pair packets at full rate.
      emit_cyc.delete();
      send(32'h4000_0006);
      send(32'hC000_0000);
      send(32'h4000_0001);
      send(32'hC000_0000);
      wait_drain();
      check("b2b_count", emit_cyc.size(), 4);
      if (emit_cyc.size() == 4) check("b2b_span", emit_cyc[3] - emit_cyc[0], 3);

      // Reset mid-packet.
      link.data_out_ready = 1'b0;
      send(32'h4000_0004);
      send(32'h8000_0044);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", link.data_out_valid, 0);
      check("midrst_in_ready", link.data_in_ready, 1);
      check("midrst_route", link.route_port, 0);
      sb.delete();
      in_pkt   = 0;
      cur_port = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      link.data_out_ready = 1'b1;
      send(32'h8000_0055);
      wait_drain();

      // Randomized traffic with random backpressure.
      done = 0;
      fork
         begin
            for (int i = 0; i < 250; i++) begin
               r = $urandom % 20;
               t = (r < 6) ? 2'b01 : (r < 13) ? 2'b10 : (r < 18) ? 2'b11 : 2'b00;
               f = {t, 30'($urandom)};
               send(f);
               if ($urandom % 3 == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               link.data_out_ready = ($urandom % 4) != 0;
            end
         end
      join
      link.data_out_ready = 1'b1;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
